s2mm_frame_gen: RTL and testbench
=================================

// Module: s2mm_frame_gen
// PURPOSE
// - Upstream stage of the S2MM controller: turns the core's unframed result stream into AXIS frames for the S2MM data FIFO.
// - Per-frame byte count (BTT) arrives on a length stream, one entry per S2MM command issued for the same transfer, in the same order.
// - Asserts tlast on the final beat of each frame and drives a partial tkeep on that beat, so the DataMover sees exact frame boundaries.
// PARAMETERS
// - AXI_DATA_WIDTH  `DFLT_CORE_AXI_DATA_WIDTH  data beat width in bits; power of 2, >= 32
// - BTT_WIDTH       23                         byte-count field width of the length entry
// PORTS
// - clk               in   1                 clock
// - rst_n             in   1                 synchronous, active-low reset
// - s_axis_len_tready out  1                 length entry accept
// - s_axis_len_tvalid in   1                 length entry valid
// - s_axis_len_tdata  in   BTT_WIDTH         frame length in bytes
// - s_axis_data_tready out 1                 core data accept
// - s_axis_data_tvalid in  1                 core data valid
// - s_axis_data_tdata in   AXI_DATA_WIDTH    core data (no framing)
// - m_axis_tready     in   1                 S2MM data FIFO ready
// - m_axis_tvalid     out  1                 framed beat valid
// - m_axis_tdata      out  AXI_DATA_WIDTH    framed data
// - m_axis_tkeep      out  AXI_DATA_WIDTH/8  byte enables
// - m_axis_tlast      out  1                 last beat of frame
// - status            out  2x32              [0]: frames done[31:16] | zero-length drops[15:0]; [1]: beats out
// BEHAVIOUR
// - Reset: state IDLE; m_axis_tvalid/tlast=0, tdata/tkeep=0; all counters and status=0; both s_* treadys=0.
// - BPB = AXI_DATA_WIDTH/8. Entry len -> beats = ceil(len/BPB); last_keep = (len%BPB==0) ? all ones : (1<<(len%BPB))-1.
// - States IDLE, STREAM. s_axis_len_tready=1 only in IDLE; s_axis_data_tready=0 in IDLE.
// - IDLE + len hs, len!=0: latch beats_left=beats-1, last_keep; next cycle STREAM.
// - IDLE + len hs, len==0: entry consumed, no beats emitted, drop counter +1 (saturates at 16'hFFFF), stay IDLE.
// - STREAM: output is a one-deep register slice; s_axis_data_tready = ~m_axis_tvalid | m_axis_tready.
// - On data hs: register beat; tkeep = (beats_left==0) ? last_keep : all ones; tlast = (beats_left==0); beats_left -= 1.
// - Data hs with beats_left==0: frame counter +1 (wraps), next state IDLE. Next len is accepted from the following cycle.
//   One-cycle gap between frames is required behaviour.
// - Output held stable while m_axis_tvalid & ~m_axis_tready; m_axis_tvalid drops only after hs with no new beat loaded.
// - Output hs and new input beat in the same cycle: register reloads, tvalid stays 1 (full throughput, 1 beat/cycle).
// - Latency: data hs to m_axis_tvalid = 1 cycle.
// - status[1] +1 per output hs (wraps at 2^32); status[0][31:16] wraps at 2^16.
// - Core data arriving in IDLE is back-pressured, never dropped or duplicated.
// - len > 2^BTT_WIDTH-1 is impossible by width; max len gives ceil((2^BTT_WIDTH-1)/BPB) beats with no counter overflow.
// - Reset mid-frame: frame abandoned, output bubble, all state and counters cleared; no partial tlast emitted.
// STRUCTURE
// - Shared package s2mm_pkg: BPB constant, BEAT_CNT_WIDTH = BTT_WIDTH-$clog2(BPB)+1, function keep_mask(len) -> last_keep.
// - Sub-module axis_reg_slice: one-deep AXIS register slice (tdata/tkeep/tlast), reused on other data paths.
// - Top level holds FSM, beat counter and status counters only.
// TESTING
// - AXI_DATA_WIDTH=512, len=128, data every cycle, tready=1 -> 2 beats; keep all ones; tlast on beat 2; status[0][31:16]=1.
// - len=70 -> 2 beats; beat 2 tkeep=64'h3F, tlast=1; status[1]=2.
// - len=0 then len=64 -> no beats for entry 1, drop count=1; one beat, tlast=1, keep all ones.
// - len=640, random tready (50%) and tvalid toggling -> 10 beats in order, data bit-exact, output stable under stall, single tlast.
// - Back-to-back entries 64,64,64 with data always valid -> 3 single-beat frames, exactly one idle cycle between frames.
// - Reset asserted on beat 3 of a len=640 frame -> next cycle m_axis_tvalid=0, status=0; new len=64 frame emits 1 beat with tlast.

Source files
------------

// File: rtl/s2mm_pkg.sv
// Shared definitions for the S2MM framing path: FSM encoding and helpers that
// derive beat counts and last-beat byte enables from a byte length.
package s2mm_pkg;

    localparam int MAX_KEEP_W = 128;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } fg_state_e;

    function automatic int bytes_per_beat(int data_width);
        return data_width / 8;
    endfunction

    // Wide enough for the full beat count; the extra bit keeps the max-length case from overflowing.
    function automatic int beat_cnt_width(int btt_width, int bpb);
        return btt_width - $clog2(bpb) + 1;
    endfunction

    // Byte enables for the final beat of a frame; callers truncate to their BPB.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(logic [31:0] len, int bpb);
        logic [MAX_KEEP_W-1:0] mask;
        int                    rem;
        rem = int'(len & 32'(bpb - 1));
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            mask[i] = (rem == 0) ? (i < bpb) : (i < rem);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI-Stream register slice carrying tdata/tkeep/tlast; sustains one
// beat per cycle because a draining beat can be replaced in the same cycle.
module axis_reg_slice #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last
);

    assign s_ready = ~m_valid | m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (s_valid && s_ready) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_keep  <= s_keep;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/s2mm_frame_gen.sv
// Cuts the core's unframed result stream into AXIS frames, one per length entry,
// marking the final beat with tlast and a partial tkeep.
`ifndef DFLT_CORE_AXI_DATA_WIDTH
`define DFLT_CORE_AXI_DATA_WIDTH 512
`endif

module s2mm_frame_gen
    import s2mm_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = `DFLT_CORE_AXI_DATA_WIDTH,
    parameter int BTT_WIDTH      = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        s_axis_len_tready,
    input  logic                        s_axis_len_tvalid,
    input  logic [BTT_WIDTH-1:0]        s_axis_len_tdata,
    output logic                        s_axis_data_tready,
    input  logic                        s_axis_data_tvalid,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axis_data_tdata,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [1:0][31:0]            status
);

    localparam int BPB            = bytes_per_beat(AXI_DATA_WIDTH);
    localparam int BPB_LOG2       = $clog2(BPB);
    localparam int BEAT_CNT_WIDTH = beat_cnt_width(BTT_WIDTH, BPB);
    localparam int LEN_W          = BTT_WIDTH + 1;

    fg_state_e                 state_reg, state_next;
    logic [BEAT_CNT_WIDTH-1:0] beats_left_reg, beats_left_next;
    logic [BPB-1:0]            last_keep_reg, last_keep_next;
    logic [15:0]               frames_reg;
    logic [15:0]               drops_reg;
    logic [31:0]               beats_out_reg;

    logic                      in_idle;
    logic                      in_stream;
    logic                      slice_ready;
    logic                      slice_valid;
    logic                      len_hs;
    logic                      data_hs;
    logic                      out_hs;
    logic [LEN_W-1:0]          len_round;
    logic [BEAT_CNT_WIDTH-1:0] len_beats;
    logic [BPB-1:0]            beat_keep;
    logic                      beat_last;

    assign in_idle   = (state_reg == ST_IDLE);
    assign in_stream = (state_reg == ST_STREAM);

    // Both treadys are forced low while reset is held so no upstream beat is lost to it.
    assign s_axis_len_tready  = rst_n & in_idle;
    assign s_axis_data_tready = rst_n & in_stream & slice_ready;
    assign slice_valid        = rst_n & in_stream & s_axis_data_tvalid;

    assign len_hs  = s_axis_len_tvalid & s_axis_len_tready;
    assign data_hs = s_axis_data_tvalid & s_axis_data_tready;
    assign out_hs  = m_axis_tvalid & m_axis_tready;

    assign len_round = {1'b0, s_axis_len_tdata} + LEN_W'(BPB - 1);
    assign len_beats = BEAT_CNT_WIDTH'(len_round >> BPB_LOG2);

    always_comb begin
        state_next      = state_reg;
        beats_left_next = beats_left_reg;
        last_keep_next  = last_keep_reg;
        beat_keep       = '1;
        beat_last       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Zero-length entries are consumed here and never reach STREAM.
                if (len_hs && (len_beats != '0)) begin
                    state_next      = ST_STREAM;
                    beats_left_next = len_beats - 1'b1;
                    last_keep_next  = BPB'(keep_mask(32'(s_axis_len_tdata), BPB));
                end
            end
            ST_STREAM: begin
                if (beats_left_reg == '0) begin
                    beat_keep = last_keep_reg;
                    beat_last = 1'b1;
                end
                if (data_hs) begin
                    beats_left_next = beats_left_reg - 1'b1;
                    if (beat_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            beats_left_reg <= '0;
            last_keep_reg  <= '0;
            frames_reg     <= '0;
            drops_reg      <= '0;
            beats_out_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            beats_left_reg <= beats_left_next;
            last_keep_reg  <= last_keep_next;
            if (len_hs && (len_beats == '0) && (drops_reg != 16'hFFFF)) begin
                drops_reg <= drops_reg + 16'd1;
            end
            if (data_hs && beat_last) begin
                frames_reg <= frames_reg + 16'd1;
            end
            if (out_hs) begin
                beats_out_reg <= beats_out_reg + 32'd1;
            end
        end
    end

    assign status[0] = {frames_reg, drops_reg};
    assign status[1] = beats_out_reg;

    axis_reg_slice #(
        .DATA_W (AXI_DATA_WIDTH),
        .KEEP_W (BPB)
    ) u_out_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (slice_valid),
        .s_ready (slice_ready),
        .s_data  (s_axis_data_tdata),
        .s_keep  (beat_keep),
        .s_last  (beat_last),
        .m_ready (m_axis_tready),
        .m_valid (m_axis_tvalid),
        .m_data  (m_axis_tdata),
        .m_keep  (m_axis_tkeep),
        .m_last  (m_axis_tlast)
    );

endmodule

// File: tb/tb_s2mm_frame_gen.sv
// Directed bench for s2mm_frame_gen at 512-bit data: table of length entries plus
// hand-written stall, back-to-back and mid-frame reset sequences.
module tb_s2mm_frame_gen;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int BW = 23;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           len_tready;
    logic           len_tvalid = 1'b0;
    logic [BW-1:0]  len_tdata = '0;
    logic           data_tready;
    logic           data_tvalid = 1'b0;
    logic [DW-1:0]  data_tdata = '0;
    logic           m_tready = 1'b1;
    logic           m_tvalid;
    logic [DW-1:0]  m_tdata;
    logic [KW-1:0]  m_tkeep;
    logic           m_tlast;
    logic [1:0][31:0] status;

    s2mm_frame_gen #(.AXI_DATA_WIDTH(DW), .BTT_WIDTH(BW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_len_tready  (len_tready),
        .s_axis_len_tvalid  (len_tvalid),
        .s_axis_len_tdata   (len_tdata),
        .s_axis_data_tready (data_tready),
        .s_axis_data_tvalid (data_tvalid),
        .s_axis_data_tdata  (data_tdata),
        .m_axis_tready      (m_tready),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tdata       (m_tdata),
        .m_axis_tkeep       (m_tkeep),
        .m_axis_tlast       (m_tlast),
        .status             (status)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int tx_idx = 0;
    int rx_idx = 0;
    bit data_toggle = 1'b0;
    bit rand_ready = 1'b0;
    int exp_frames = 0;
    int exp_drops = 0;
    int exp_beats = 0;

    logic [KW-1:0] q_keep[$];
    logic          q_last[$];
    int            q_cyc[$];

    typedef struct {
        int          len;
        int          beats;
        logic [63:0] keep;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [DW-1:0] make_word(int idx);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = 32'(idx) * 32'h9E37_79B9 + 32'(i);
        end
        return w;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Core data source: sequential words, advanced only on an accepted beat.
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = rst_n && data_tvalid && data_tready;
            @(posedge clk);
            #1;
            if (hs) tx_idx++;
            data_tvalid = !data_toggle || ($urandom_range(0, 1) == 1);
            data_tdata  = make_word(tx_idx);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = !rand_ready || ($urandom_range(0, 1) == 1);
        end
    end

    // Output monitor: order, stall stability, and per-beat capture.
    initial begin
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data;
        logic [KW-1:0] prev_keep;
        logic          prev_last;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("stall_hold", 64'(m_tvalid && m_tdata == prev_data && m_tkeep == prev_keep
                                        && m_tlast == prev_last), 64'd1);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_keep  = m_tkeep;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                if (m_tdata !== make_word(rx_idx)) begin
                    tests++;
                    fails++;
                    $display("FAIL data_order: beat %0d word0 got %0h, expected %0h",
                             rx_idx, m_tdata[31:0], make_word(rx_idx) & 512'hFFFF_FFFF);
                end else begin
                    tests++;
                end
                rx_idx++;
                q_keep.push_back(m_tkeep);
                q_last.push_back(m_tlast);
                q_cyc.push_back(cycle);
            end
        end
    end

    task automatic clear_q();
        q_keep.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send_len(int len);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        len_tvalid = 1'b1;
        len_tdata  = BW'(len);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (len_tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("len_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        len_tvalid = 1'b0;
    endtask

    task automatic wait_beats(int n);
        for (int c = 0; c < 3000 && q_keep.size() < n; c++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(string name, int len, int beats, logic [63:0] keep, bit tput);
        int lasts = 0;
        int full_keeps = 0;
        clear_q();
        send_len(len);
        wait_beats(beats);
        check({name, "_beats"}, 64'(q_keep.size()), 64'(beats));
        if (beats > 0 && q_keep.size() == beats) begin
            for (int i = 0; i < beats; i++) begin
                if (q_last[i]) lasts++;
                if (i < beats - 1 && q_keep[i] == KW'(ALL_ONES)) full_keeps++;
            end
            check({name, "_last_keep"}, 64'(q_keep[beats-1]), keep);
            check({name, "_tlast_on_final"}, 64'(q_last[beats-1]), 64'd1);
            check({name, "_tlast_count"}, 64'(lasts), 64'd1);
            if (beats > 1) check({name, "_mid_keep"}, 64'(full_keeps), 64'(beats - 1));
            if (tput) check({name, "_throughput"}, 64'(q_cyc[beats-1] - q_cyc[0]), 64'(beats - 1));
        end
        if (beats > 0) exp_frames++;
        else           exp_drops++;
        exp_beats += beats;
        check({name, "_status0"}, 64'(status[0]), 64'({exp_frames[15:0], exp_drops[15:0]}));
        check({name, "_status1"}, 64'(status[1]), 64'(exp_beats));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len: 128, beats: 2, keep: ALL_ONES};
        vecs[1] = '{len: 70,  beats: 2, keep: 64'h3F};
        vecs[2] = '{len: 0,   beats: 0, keep: 64'h0};
        vecs[3] = '{len: 64,  beats: 1, keep: ALL_ONES};
        vecs[4] = '{len: 1,   beats: 1, keep: 64'h1};
        vecs[5] = '{len: 127, beats: 2, keep: 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[6] = '{len: 130, beats: 3, keep: 64'h3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tkeep", 64'(m_tkeep), 64'd0);
        check("rst_tdata_zero", 64'(m_tdata == '0), 64'd1);
        check("rst_status", 64'(status), 64'd0);
        check("rst_len_tready", 64'(len_tready), 64'd0);
        check("rst_data_tready", 64'(data_tready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rx_idx = tx_idx;
        check("idle_len_tready", 64'(len_tready), 64'd1);
        check("idle_data_tready", 64'(data_tready), 64'd0);

        for (int v = 0; v < 7; v++) begin
            run_frame($sformatf("vec%0d_len%0d", v, vecs[v].len), vecs[v].len,
                      vecs[v].beats, vecs[v].keep, 1'b1);
        end

        // Random output stalls and input bubbles on a 10-beat frame.
        rand_ready  = 1'b1;
        data_toggle = 1'b1;
        run_frame("stall_len640", 640, 10, ALL_ONES, 1'b0);
        rand_ready  = 1'b0;
        data_toggle = 1'b0;
        repeat (3) @(posedge clk);

        // Back-to-back single-beat entries with len valid continuously.
        clear_q();
        @(posedge clk);
        #1;
        len_tvalid = 1'b1;
        len_tdata  = BW'(64);
        for (int k = 0; k < 3; k++) begin
            bit got = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (len_tready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) check("b2b_len_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
            if (k == 2) len_tvalid = 1'b0;
        end
        wait_beats(3);
        check("b2b_beats", 64'(q_keep.size()), 64'd3);
        if (q_keep.size() == 3) begin
            check("b2b_gap1", 64'(q_cyc[1] - q_cyc[0]), 64'd2);
            check("b2b_gap2", 64'(q_cyc[2] - q_cyc[1]), 64'd2);
            check("b2b_lasts", 64'({q_last[0], q_last[1], q_last[2]}), 64'b111);
        end
        exp_frames += 3;
        exp_beats  += 3;
        check("b2b_status0", 64'(status[0]), 64'({exp_frames[15:0], exp_drops[15:0]}));
        check("b2b_status1", 64'(status[1]), 64'(exp_beats));

        // Reset while beat 3 of a 10-beat frame sits in the output register.
        clear_q();
        send_len(640);
        for (int c = 0; c < 200 && q_keep.size() < 2; c++) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_status", 64'(status), 64'd0);
        check("midrst_data_tready", 64'(data_tready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rx_idx     = tx_idx;
        exp_frames = 0;
        exp_drops  = 0;
        exp_beats  = 0;
        check("midrst_no_tlast", 64'(q_last.size() > 0 && q_last[q_last.size()-1]), 64'd0);
        run_frame("post_rst_len64", 64, 1, ALL_ONES, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
